// File: rtl/pd_tx_sequencer.sv
// pd_tx_sequencer: round-robin arbiter over miner-core found-hash requests, latching the
// winning 288-bit packet, then sequencing the 20-word shifter handshake to the transmitter.
// Optional build macro PD_TX_TIMEOUT_EN: abort a packet after TIMEOUT_CYCLES consecutive
// stalled SEND cycles (tx_timeout + data_sent pulse). Without it SEND waits indefinitely.
module pd_tx_sequencer #(
    parameter int unsigned N_CORES        = 4,
    parameter int unsigned PKT_WORDS      = 20,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic                   clk,
    input  logic                   n_rst,
    input  logic [N_CORES-1:0]     req,
    input  logic [N_CORES*288-1:0] hash_in,
    output logic [N_CORES-1:0]     grant,
    output logic [287:0]           valid_hash,
    output logic                   PID_en,
    output logic                   transmit_empty_en,
    input  logic                   tx_ready,
    output logic                   tx_valid,
    output logic                   read_enable,
    output logic                   data_sent,
    output logic [4:0]             word_idx,
    output logic                   busy,
    output logic                   tx_timeout
);

    localparam int unsigned PW        = (N_CORES > 1) ? $clog2(N_CORES) : 1;
    localparam logic [4:0]  LAST_WORD = 5'(PKT_WORDS - 1);

    typedef enum logic [1:0] {StIdle, StLatch, StSend, StDone} state_e;

    state_e             state_q, state_d;
    logic [PW-1:0]      ptr_q, ptr_d;
    logic [PW-1:0]      winner_q, winner_d;
    logic [N_CORES-1:0] grant_q, grant_d;
    logic [287:0]       hash_q, hash_d;
    logic [4:0]         idx_q, idx_d;

    logic               win_found;
    logic [PW-1:0]      win_idx;
    logic [PW:0]        cand;
    logic [287:0]       hash_arr [N_CORES];

    for (genvar g = 0; g < N_CORES; g++) begin : g_slice
        assign hash_arr[g] = hash_in[g*288 +: 288];
    end

    // Round-robin search: first set request strictly after the pointer, wrapping.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int unsigned i = 1; i <= N_CORES; i++) begin
            cand = {1'b0, ptr_q} + (PW+1)'(i);
            if (cand >= (PW+1)'(N_CORES)) begin
                cand = cand - (PW+1)'(N_CORES);
            end
            if (!win_found && req[cand[PW-1:0]]) begin
                win_found = 1'b1;
                win_idx   = cand[PW-1:0];
            end
        end
    end

`ifdef PD_TX_TIMEOUT_EN
    localparam int unsigned SW = $clog2(TIMEOUT_CYCLES + 1);

    logic [SW-1:0] stall_q, stall_d;
    logic          abort_q, abort_d;

    // Consecutive-stall counter; the cycle after it expires carries the abort pulse.
    always_comb begin
        stall_d = '0;
        abort_d = 1'b0;
        if (state_q == StSend && !tx_ready) begin
            if (stall_q == SW'(TIMEOUT_CYCLES - 1)) begin
                abort_d = 1'b1;
            end else begin
                stall_d = stall_q + 1'b1;
            end
        end
    end

    // Stall counter and abort pulse registers.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            stall_q <= '0;
            abort_q <= 1'b0;
        end else begin
            stall_q <= stall_d;
            abort_q <= abort_d;
        end
    end
`else
    logic abort_d;
    logic abort_q;
    logic unused_timeout;

    assign abort_d        = 1'b0;
    assign abort_q        = 1'b0;
    assign unused_timeout = ^TIMEOUT_CYCLES;
`endif

    // Next-state: arbitration in IDLE, pointer update in LATCH, word counting in SEND.
    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        winner_d = winner_q;
        grant_d  = '0;
        hash_d   = hash_q;
        idx_d    = idx_q;
        unique case (state_q)
            StIdle: begin
                if (win_found) begin
                    hash_d   = hash_arr[win_idx];
                    grant_d  = N_CORES'(1) << win_idx;
                    winner_d = win_idx;
                    state_d  = StLatch;
                end
            end
            StLatch: begin
                ptr_d   = winner_q;
                idx_d   = '0;
                state_d = StSend;
            end
            StSend: begin
                if (tx_ready) begin
                    if (idx_q == LAST_WORD) begin
                        idx_d   = '0;
                        state_d = StDone;
                    end else begin
                        idx_d = idx_q + 5'd1;
                    end
                end else if (abort_d) begin
                    // Stalled too long: drop the packet, keep the pointer on the aborted winner.
                    idx_d   = '0;
                    state_d = StIdle;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State registers; pointer resets to the last core so core 0 wins first.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q  <= StIdle;
            ptr_q    <= PW'(N_CORES - 1);
            winner_q <= '0;
            grant_q  <= '0;
            hash_q   <= '0;
            idx_q    <= '0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            winner_q <= winner_d;
            grant_q  <= grant_d;
            hash_q   <= hash_d;
            idx_q    <= idx_d;
        end
    end

    // Outputs decoded from the current state; grant_q is only non-zero during LATCH.
    always_comb begin
        grant             = grant_q;
        valid_hash        = hash_q;
        PID_en            = (state_q == StLatch);
        transmit_empty_en = (state_q == StLatch);
        tx_valid          = (state_q == StSend);
        read_enable       = (state_q == StSend) & tx_ready;
        data_sent         = (state_q == StDone) | abort_q;
        word_idx          = idx_q;
        busy              = (state_q != StIdle);
        tx_timeout        = abort_q;
    end

endmodule

// File: tb/tb_pd_tx_sequencer.sv
// Self-checking bench for pd_tx_sequencer: directed scenarios plus a randomized run checked
// against a packet-level reference model (round-robin pick, 20 accepted words per packet).
module tb_pd_tx_sequencer;

    localparam int N  = 4;
    localparam int TO = 16;

    logic             clk = 1'b0;
    logic             n_rst;
    logic [N-1:0]     req;
    logic [N*288-1:0] hash_in;
    logic [287:0]     hw [N];
    logic [N-1:0]     grant;
    logic [287:0]     valid_hash;
    logic             PID_en, transmit_empty_en, tx_ready, tx_valid, read_enable;
    logic             data_sent, busy, tx_timeout;
    logic [4:0]       word_idx;

    int n_checks = 0;
    int n_fail   = 0;
    int m_ptr;

    for (genvar g = 0; g < N; g++) begin : g_hash
        assign hash_in[g*288 +: 288] = hw[g];
    end

    always #5 clk = ~clk;

    pd_tx_sequencer #(
        .N_CORES(N), .PKT_WORDS(20), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk), .n_rst(n_rst), .req(req), .hash_in(hash_in), .grant(grant),
        .valid_hash(valid_hash), .PID_en(PID_en), .transmit_empty_en(transmit_empty_en),
        .tx_ready(tx_ready), .tx_valid(tx_valid), .read_enable(read_enable),
        .data_sent(data_sent), .word_idx(word_idx), .busy(busy), .tx_timeout(tx_timeout)
    );

    // Reference round-robin: first requester after ptr, wrapping.
    function automatic int pick(input logic [N-1:0] r, input int ptr);
        logic [N-1:0] sh;
        for (int i = 1; i <= N; i++) begin
            sh = r >> ((ptr + i) % N);
            if (sh[0]) return (ptr + i) % N;
        end
        return -1;
    endfunction

    function automatic logic [N-1:0] onehot(input int w);
        return N'(1) << w;
    endfunction

    function automatic logic [287:0] rand288();
        logic [287:0] v;
        v = '0;
        for (int i = 0; i < 9; i++) v = {v[255:0], 32'($urandom)};
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        req = '0;
        tx_ready = 1'b1;
        repeat (25) tick();
    endtask

    task automatic test_reset();
        req = '0;
        tx_ready = 1'b1;
        for (int c = 0; c < N; c++) hw[c] = '0;
        #3 n_rst = 1'b0;
        #1;
        n_checks++;
        if ({grant, PID_en, transmit_empty_en, tx_valid, read_enable, data_sent, busy,
             tx_timeout} !== '0) begin
            n_fail++;
            $display("FAIL reset_ctrl: got %b expected all 0", {grant, PID_en,
                     transmit_empty_en, tx_valid, read_enable, data_sent, busy, tx_timeout});
        end
        n_checks++;
        if (word_idx !== 5'd0) begin
            n_fail++;
            $display("FAIL reset_word_idx: got %0d expected 0", word_idx);
        end
        n_checks++;
        if (valid_hash !== '0) begin
            n_fail++;
            $display("FAIL reset_valid_hash: got %h expected 0", valid_hash);
        end
        repeat (3) tick();
        n_rst = 1'b1;
        m_ptr = N - 1;
        tick();
    endtask

    task automatic test_round_robin();
        int w, ds, waitc;
        req = '1;
        tx_ready = 1'b1;
        for (int p = 0; p < 5; p++) begin
            w = pick(req, m_ptr);
            for (int c = 0; c < N; c++) hw[c] = rand288();
            ds = 0;
            waitc = 0;
            #1;
            while (grant === '0 && waitc < 40) begin
                if (data_sent === 1'b1) ds++;
                tick();
                #1;
                waitc++;
            end
            n_checks++;
            if (grant !== onehot(w)) begin
                n_fail++;
                $display("FAIL rr_grant[%0d]: got %b expected %b", p, grant, onehot(w));
            end
            n_checks++;
            if (valid_hash !== hw[w]) begin
                n_fail++;
                $display("FAIL rr_hash[%0d]: got %h expected %h", p, valid_hash, hw[w]);
            end
            n_checks++;
            if (ds !== ((p > 0) ? 1 : 0)) begin
                n_fail++;
                $display("FAIL rr_data_sent[%0d]: got %0d pulses expected %0d", p, ds,
                         (p > 0) ? 1 : 0);
            end
            m_ptr = w;
            tick();
        end
        drain();
    endtask

    task automatic test_single();
        logic [287:0] h;
        int bad;
        h = rand288();
        hw[2] = h;
        req = 4'b0100;
        tx_ready = 1'b1;
        #1;
        n_checks++;
        if (busy !== 1'b0 || grant !== '0) begin
            n_fail++;
            $display("FAIL single_idle: got busy=%b grant=%b expected 0/0", busy, grant);
        end
        tick();
        req = '0;
        #1;
        n_checks++;
        if (grant !== 4'b0100) begin
            n_fail++;
            $display("FAIL single_grant: got %b expected 0100", grant);
        end
        n_checks++;
        if ({PID_en, transmit_empty_en, busy, tx_valid} !== 4'b1110) begin
            n_fail++;
            $display("FAIL single_latch: got %b expected 1110",
                     {PID_en, transmit_empty_en, busy, tx_valid});
        end
        m_ptr = 2;
        bad = 0;
        for (int k = 0; k < 20; k++) begin
            tick();
            #1;
            if (tx_valid !== 1'b1 || read_enable !== 1'b1 || word_idx !== 5'(k) ||
                valid_hash !== h || data_sent !== 1'b0) bad++;
        end
        n_checks++;
        if (bad !== 0) begin
            n_fail++;
            $display("FAIL single_words: got %0d bad word cycles expected 0", bad);
        end
        tick();
        #1;
        n_checks++;
        if ({data_sent, tx_valid, busy} !== 3'b101) begin
            n_fail++;
            $display("FAIL single_done: got %b expected 101", {data_sent, tx_valid, busy});
        end
        tick();
        #1;
        n_checks++;
        if ({busy, data_sent} !== 2'b00) begin
            n_fail++;
            $display("FAIL single_idle_after: got %b expected 00", {busy, data_sent});
        end
        drain();
    endtask

    task automatic test_backpressure();
        logic [287:0] h;
        int sendc, rec, drop, k;
        logic done;
        h = rand288();
        hw[0] = h;
        req = 4'b0001;
        tx_ready = 1'b0;
        tick();
        req = '0;
        #1;
        n_checks++;
        if (grant !== 4'b0001) begin
            n_fail++;
            $display("FAIL bp_grant: got %b expected 0001", grant);
        end
        m_ptr = 0;
        sendc = 0; rec = 0; drop = 0; k = 0; done = 1'b0;
        while (!done && k < 100) begin
            tick();
            tx_ready = (k % 2 == 1);
            #1;
            if (data_sent === 1'b1) done = 1'b1;
            else begin
                if (tx_valid === 1'b1) sendc++;
                else drop++;
                if (read_enable === 1'b1) rec++;
            end
            k++;
        end
        n_checks++;
        if (!done || sendc !== 40) begin
            n_fail++;
            $display("FAIL bp_send_cycles: got %0d (done=%b) expected 40", sendc, done);
        end
        n_checks++;
        if (rec !== 20) begin
            n_fail++;
            $display("FAIL bp_read_enable: got %0d expected 20", rec);
        end
        n_checks++;
        if (drop !== 0) begin
            n_fail++;
            $display("FAIL bp_valid_drop: got %0d cycles expected 0", drop);
        end
        n_checks++;
        if (valid_hash !== h) begin
            n_fail++;
            $display("FAIL bp_hash: got %h expected %h", valid_hash, h);
        end
        drain();
    endtask

    task automatic test_hold_ignore();
        logic [287:0] h0, h1;
        int bad, k;
        logic done;
        h0 = rand288();
        h1 = rand288();
        hw[0] = h0;
        hw[1] = h1;
        req = 4'b0001;
        tx_ready = 1'b1;
        tick();
        req = '0;
        #1;
        n_checks++;
        if (grant !== 4'b0001) begin
            n_fail++;
            $display("FAIL hold_grant0: got %b expected 0001", grant);
        end
        bad = 0; k = 0; done = 1'b0;
        while (!done && k < 40) begin
            tick();
            if (k == 5) req = 4'b0010;
            if (k == 8) hw[0] = ~h0;
            #1;
            if (data_sent === 1'b1) done = 1'b1;
            else if (valid_hash !== h0 || grant !== '0) bad++;
            k++;
        end
        n_checks++;
        if (!done || bad !== 0) begin
            n_fail++;
            $display("FAIL hold_stable: got %0d bad cycles (done=%b) expected 0", bad, done);
        end
        tick();
        #1;
        n_checks++;
        if (grant !== '0) begin
            n_fail++;
            $display("FAIL hold_gap: got %b expected 0000", grant);
        end
        tick();
        #1;
        n_checks++;
        if (grant !== 4'b0010 || valid_hash !== h1) begin
            n_fail++;
            $display("FAIL hold_grant1: got %b/%h expected 0010/%h", grant, valid_hash, h1);
        end
        m_ptr = 1;
        drain();
    endtask

    task automatic test_timeout();
        int bad;
        hw[0] = rand288();
        req = 4'b0001;
        tx_ready = 1'b1;
        tick();
        req = '0;
        #1;
        m_ptr = 0;
        repeat (3) tick();
        bad = 0;
`ifdef PD_TX_TIMEOUT_EN
        for (int s = 0; s < TO; s++) begin
            tick();
            tx_ready = 1'b0;
            #1;
            if (tx_timeout !== 1'b0 || tx_valid !== 1'b1 || word_idx !== 5'd3) bad++;
        end
        n_checks++;
        if (bad !== 0) begin
            n_fail++;
            $display("FAIL to_stall: got %0d bad cycles expected 0", bad);
        end
        tick();
        #1;
        n_checks++;
        if ({tx_timeout, data_sent, busy, tx_valid} !== 4'b1100 || word_idx !== 5'd0) begin
            n_fail++;
            $display("FAIL to_pulse: got %b idx %0d expected 1100 idx 0",
                     {tx_timeout, data_sent, busy, tx_valid}, word_idx);
        end
        tick();
        #1;
        n_checks++;
        if ({tx_timeout, data_sent} !== 2'b00) begin
            n_fail++;
            $display("FAIL to_single: got %b expected 00", {tx_timeout, data_sent});
        end
`else
        for (int s = 0; s < 40; s++) begin
            tick();
            tx_ready = 1'b0;
            #1;
            if (busy !== 1'b1 || tx_timeout !== 1'b0 || data_sent !== 1'b0 ||
                word_idx !== 5'd3) bad++;
        end
        n_checks++;
        if (bad !== 0) begin
            n_fail++;
            $display("FAIL no_to_stall: got %0d bad cycles expected 0", bad);
        end
`endif
        drain();
    endtask

    task automatic test_async_reset();
        logic [287:0] h;
        hw[0] = rand288();
        req = 4'b0001;
        tx_ready = 1'b1;
        tick();
        req = '0;
        repeat (8) tick();
        #1;
        n_checks++;
        if (word_idx !== 5'd7) begin
            n_fail++;
            $display("FAIL ar_pre_idx: got %0d expected 7", word_idx);
        end
        n_rst = 1'b0;
        #1;
        n_checks++;
        if ({grant, PID_en, transmit_empty_en, tx_valid, read_enable, data_sent, busy,
             tx_timeout, word_idx} !== '0) begin
            n_fail++;
            $display("FAIL ar_outputs: got %b expected all 0", {grant, PID_en,
                     transmit_empty_en, tx_valid, read_enable, data_sent, busy, tx_timeout,
                     word_idx});
        end
        n_checks++;
        if (valid_hash !== '0) begin
            n_fail++;
            $display("FAIL ar_hash: got %h expected 0", valid_hash);
        end
        tick();
        n_checks++;
        if ({data_sent, busy} !== 2'b00) begin
            n_fail++;
            $display("FAIL ar_held: got %b expected 00", {data_sent, busy});
        end
        n_rst = 1'b1;
        m_ptr = N - 1;
        h = rand288();
        hw[1] = h;
        req = 4'b0010;
        tick();
        req = '0;
        #1;
        n_checks++;
        if (grant !== 4'b0010 || valid_hash !== h) begin
            n_fail++;
            $display("FAIL ar_regrant: got %b/%h expected 0010/%h", grant, valid_hash, h);
        end
        m_ptr = 1;
        tick();
        #1;
        n_checks++;
        if (tx_valid !== 1'b1 || word_idx !== 5'd0) begin
            n_fail++;
            $display("FAIL ar_word0: got valid %b idx %0d expected 1 idx 0", tx_valid,
                     word_idx);
        end
        drain();
    endtask

    task automatic test_random();
        int ph, nph, w, widx, stall;
        logic pend, have;
        logic [287:0] mh;
        logic [N-1:0] e_grant;
        logic e_pid, e_txv, e_ds, e_busy, e_to;
        logic [4:0] e_idx;
        logic [N+11:0] got, expv;
        ph = 0; widx = 0; stall = 0; w = 0;
        pend = 1'b0; have = 1'b0; mh = '0;
        for (int cyc = 0; cyc < 1500; cyc++) begin
            if ($urandom_range(0, 3) == 0) req = N'($urandom);
            hw[$urandom_range(0, N - 1)] = rand288();
            tx_ready = ($urandom_range(0, 3) != 0);
            #1;
            if (have) begin
                n_checks++;
                if (valid_hash !== mh) begin
                    n_fail++;
                    $display("FAIL rand_hash@%0d: got %h expected %h", cyc, valid_hash, mh);
                end
            end
            e_grant = '0; e_pid = 1'b0; e_txv = 1'b0; e_idx = '0;
            e_ds = (ph == 3) || pend;
            e_to = pend;
            e_busy = (ph != 0);
            pend = 1'b0;
            nph = ph;
            case (ph)
                0: if (req !== '0) begin
                    w = pick(req, m_ptr);
                    mh = hw[w];
                    have = 1'b1;
                    nph = 1;
                end
                1: begin
                    e_grant = onehot(w);
                    e_pid = 1'b1;
                    m_ptr = w;
                    widx = 0;
                    stall = 0;
                    nph = 2;
                end
                2: begin
                    e_txv = 1'b1;
                    e_idx = 5'(widx);
                    if (tx_ready) begin
                        stall = 0;
                        if (widx == 19) begin
                            widx = 0;
                            nph = 3;
                        end else widx++;
                    end else begin
                        stall++;
`ifdef PD_TX_TIMEOUT_EN
                        if (stall == TO) begin
                            widx = 0;
                            stall = 0;
                            pend = 1'b1;
                            nph = 0;
                        end
`endif
                    end
                end
                default: nph = 0;
            endcase
            got  = {grant, PID_en, transmit_empty_en, tx_valid, read_enable, data_sent, busy,
                    tx_timeout, word_idx};
            expv = {e_grant, e_pid, e_pid, e_txv, e_txv & tx_ready, e_ds, e_busy, e_to, e_idx};
            n_checks++;
            if (got !== expv) begin
                n_fail++;
                $display("FAIL rand_ctrl@%0d: got %b expected %b", cyc, got, expv);
            end
            ph = nph;
            tick();
        end
    endtask

    initial begin
        n_rst = 1'b1;
        req = '0;
        tx_ready = 1'b0;
        m_ptr = N - 1;
        test_reset();
        test_round_robin();
        test_single();
        test_backpressure();
        test_hold_ignore();
        test_timeout();
        test_async_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "simulation time limit");
    end

endmodule
